// File: rtl/cronometro_regresivo_if.sv
// Control strobes, load value and time/status outputs of the countdown chronometer.
`timescale 1ns/1ps
interface cronometro_regresivo_if;
  logic       LOAD;
  logic [7:0] HH_IN;
  logic [7:0] MM_IN;
  logic [7:0] SS_IN;
  logic       START;
  logic       STOP;
  logic       ALARM_ACK;
  logic [7:0] HH;
  logic [7:0] MM;
  logic [7:0] SS;
  logic       RUNNING;
  logic       DONE;
  logic       FIN_CRONOM;

  modport master (
    output LOAD, HH_IN, MM_IN, SS_IN, START, STOP, ALARM_ACK,
    input  HH, MM, SS, RUNNING, DONE, FIN_CRONOM
  );

  modport slave (
    input  LOAD, HH_IN, MM_IN, SS_IN, START, STOP, ALARM_ACK,
    output HH, MM, SS, RUNNING, DONE, FIN_CRONOM
  );
endinterface

// File: rtl/cronometro_regresivo.sv
// BCD HH:MM:SS countdown at one decrement per TICK_CYCLES clocks; pulses FIN_CRONOM
// once when the count reaches 00:00:00.
`timescale 1ns/1ps
module cronometro_regresivo #(
  parameter int unsigned TICK_CYCLES = 100000000
) (
  input logic                   CLK_NexYs,
  input logic                   RST,
  cronometro_regresivo_if.slave crono
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    hh_q, mm_q, ss_q, hh_d, mm_d, ss_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          fin_q, fin_d;

  logic [7:0]    hh_ld, mm_ld, ss_ld;
  logic [8:0]    ss_chain, mm_chain;
  logic [7:0]    hh_step, hh_dec, mm_dec, ss_dec;
  logic          time_zero, dec_zero;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [7:0] clamp_field(input logic [7:0] v, input logic [7:0] maxv);
    logic [7:0] c;
    c = {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    return (c > maxv) ? maxv : c;
  endfunction

  // {borrow_out, field - 1} for a 00..59 BCD field; 00 wraps to 59 with borrow.
  function automatic logic [8:0] dec_field(input logic [7:0] v);
    if (v[3:0] != 4'd0)      return {1'b0, v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0) return {1'b0, v[7:4] - 4'd1, 4'd9};
    else                     return {1'b1, 4'd5, 4'd9};
  endfunction

  assign hh_ld = clamp_field(crono.HH_IN, 8'h23);
  assign mm_ld = clamp_field(crono.MM_IN, 8'h59);
  assign ss_ld = clamp_field(crono.SS_IN, 8'h59);

  // Hours never borrow: 00:00:00 ends the count before HH=00 would need to.
  assign ss_chain = dec_field(ss_q);
  assign mm_chain = dec_field(mm_q);
  assign hh_step  = (hh_q[3:0] != 4'd0) ? {hh_q[7:4], hh_q[3:0] - 4'd1}
                                        : {hh_q[7:4] - 4'd1, 4'd9};
  assign ss_dec   = ss_chain[7:0];
  assign mm_dec   = ss_chain[8] ? mm_chain[7:0] : mm_q;
  assign hh_dec   = (ss_chain[8] && mm_chain[8]) ? hh_step : hh_q;

  assign time_zero = ({hh_q, mm_q, ss_q} == 24'h0);
  assign dec_zero  = ({hh_dec, mm_dec, ss_dec} == 24'h0);

  always_comb begin
    state_d = state_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    presc_d = presc_q;
    fin_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (crono.LOAD) begin
          hh_d = hh_ld;
          mm_d = mm_ld;
          ss_d = ss_ld;
        end else if (crono.START && !crono.STOP && !time_zero) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        // A tick on the STOP edge still decrements; reaching zero outranks the pause.
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          hh_d    = hh_dec;
          mm_d    = mm_dec;
          ss_d    = ss_dec;
          if (dec_zero) begin
            state_d = ST_DONE;
            fin_d   = 1'b1;
          end else if (crono.STOP) begin
            state_d = ST_PAUSE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          if (crono.STOP) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (crono.LOAD) begin
          hh_d    = hh_ld;
          mm_d    = mm_ld;
          ss_d    = ss_ld;
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (crono.START && !crono.STOP) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (crono.LOAD) begin
          hh_d    = hh_ld;
          mm_d    = mm_ld;
          ss_d    = ss_ld;
          state_d = ST_IDLE;
        end else if (crono.ALARM_ACK) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_NexYs or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      presc_q <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      presc_q <= presc_d;
      fin_q   <= fin_d;
    end
  end

  assign crono.HH         = hh_q;
  assign crono.MM         = mm_q;
  assign crono.SS         = ss_q;
  assign crono.RUNNING    = (state_q == ST_RUN);
  assign crono.DONE       = (state_q == ST_DONE);
  assign crono.FIN_CRONOM = fin_q;

endmodule

// File: tb/tb_cronometro_regresivo.sv
// Scoreboard bench for cronometro_regresivo with a 10-cycle tick.
`timescale 1ns/1ps
module tb_cronometro_regresivo;

  localparam int unsigned TICKS = 10;

  logic CLK_NexYs = 1'b0;
  logic RST       = 1'b1;

  cronometro_regresivo_if ifc();

  cronometro_regresivo #(.TICK_CYCLES(TICKS)) dut (
    .CLK_NexYs (CLK_NexYs),
    .RST       (RST),
    .crono     (ifc)
  );

  always #5 CLK_NexYs = ~CLK_NexYs;

  typedef struct {
    logic [23:0] t;
    int unsigned at;
    logic        fin;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  compared   = 0;
  int  mismatched = 0;

  function automatic logic [23:0] now_t();
    return {ifc.HH, ifc.MM, ifc.SS};
  endfunction

  task automatic step();
    @(posedge CLK_NexYs);
    #1;
  endtask

  task automatic strobe(input logic ld, input logic st, input logic sp, input logic ak);
    ifc.LOAD = ld; ifc.START = st; ifc.STOP = sp; ifc.ALARM_ACK = ak;
    step();
    ifc.LOAD = 1'b0; ifc.START = 1'b0; ifc.STOP = 1'b0; ifc.ALARM_ACK = 1'b0;
  endtask

  task automatic set_inputs(input logic [23:0] t);
    ifc.HH_IN = t[23:16]; ifc.MM_IN = t[15:8]; ifc.SS_IN = t[7:0];
  endtask

  // Pause if running, then load: leaves the DUT in IDLE holding t.
  task automatic idle_load(input logic [23:0] t);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    set_inputs(t);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Records every cycle where the time changes or FIN_CRONOM is high.
  task automatic observe(input int unsigned n);
    logic [23:0] prev;
    prev = now_t();
    for (int unsigned i = 1; i <= n; i++) begin
      step();
      if (now_t() !== prev || ifc.FIN_CRONOM) begin
        obs_q.push_back('{t: now_t(), at: i, fin: ifc.FIN_CRONOM});
        prev = now_t();
      end
    end
  endtask

  task automatic test_reset();
    ifc.LOAD = 1'b0; ifc.START = 1'b0; ifc.STOP = 1'b0; ifc.ALARM_ACK = 1'b0;
    set_inputs(24'h0);
    RST = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    step();
    compared++; if (now_t() !== 24'h0) begin mismatched++; $display("FAIL reset_time: got %h required 000000", now_t()); end
    compared++; if (ifc.RUNNING !== 1'b0) begin mismatched++; $display("FAIL reset_running: got %b required 0", ifc.RUNNING); end
    compared++; if (ifc.DONE !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b required 0", ifc.DONE); end
    compared++; if (ifc.FIN_CRONOM !== 1'b0) begin mismatched++; $display("FAIL reset_fin: got %b required 0", ifc.FIN_CRONOM); end
  endtask

  task automatic test_countdown();
    ev_t e, o;
    idle_load(24'h000003);
    compared++; if (now_t() !== 24'h000003) begin mismatched++; $display("FAIL load_latency: got %h required 000003", now_t()); end
    exp_q.push_back('{t: 24'h000002, at: 10, fin: 1'b0});
    exp_q.push_back('{t: 24'h000001, at: 20, fin: 1'b0});
    exp_q.push_back('{t: 24'h000000, at: 30, fin: 1'b1});
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    compared++; if (ifc.RUNNING !== 1'b1) begin mismatched++; $display("FAIL start_running: got %b required 1", ifc.RUNNING); end
    observe(40);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      compared++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); mismatched++;
        $display("FAIL countdown_seq: got %h fin=%b @%0d required no update", o.t, o.fin, o.at);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); mismatched++;
        $display("FAIL countdown_seq: got no update required %h fin=%b @%0d", e.t, e.fin, e.at);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.t !== e.t || o.at !== e.at || o.fin !== e.fin) begin
          mismatched++;
          $display("FAIL countdown_seq: got %h fin=%b @%0d required %h fin=%b @%0d", o.t, o.fin, o.at, e.t, e.fin, e.at);
        end
      end
    end
    compared++; if (ifc.DONE !== 1'b1 || ifc.RUNNING !== 1'b0) begin mismatched++; $display("FAIL countdown_status: got done=%b run=%b required done=1 run=0", ifc.DONE, ifc.RUNNING); end
  endtask

  task automatic test_borrow();
    logic [23:0] ld_tab [5]  = '{24'h010000, 24'h001000, 24'h200000, 24'h000010, 24'h123450};
    logic [23:0] exp_tab [5] = '{24'h005959, 24'h000959, 24'h195959, 24'h000009, 24'h123449};
    ev_t e, o;
    for (int unsigned k = 0; k < 5; k++) begin
      idle_load(ld_tab[k]);
      strobe(1'b0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back('{t: exp_tab[k], at: 10, fin: 1'b0});
      observe(10);
      while (exp_q.size() != 0 || obs_q.size() != 0) begin
        compared++;
        if (exp_q.size() == 0) begin
          o = obs_q.pop_front(); mismatched++;
          $display("FAIL borrow_%0d: got %h fin=%b @%0d required no update", k, o.t, o.fin, o.at);
        end else if (obs_q.size() == 0) begin
          e = exp_q.pop_front(); mismatched++;
          $display("FAIL borrow_%0d: got no update required %h @%0d", k, e.t, e.at);
        end else begin
          e = exp_q.pop_front(); o = obs_q.pop_front();
          if (o.t !== e.t || o.at !== e.at || o.fin !== e.fin) begin
            mismatched++;
            $display("FAIL borrow_%0d: got %h fin=%b @%0d required %h fin=%b @%0d", k, o.t, o.fin, o.at, e.t, e.fin, e.at);
          end
        end
      end
    end
  endtask

  task automatic test_pause();
    ev_t e, o;
    idle_load(24'h000005);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back('{t: 24'h000004, at: 10, fin: 1'b0});
    observe(14);
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    observe(50);
    compared++; if (ifc.RUNNING !== 1'b0 || now_t() !== 24'h000004) begin mismatched++; $display("FAIL pause_hold: got %h run=%b required 000004 run=0", now_t(), ifc.RUNNING); end
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back('{t: 24'h000003, at: 5, fin: 1'b0});
    observe(6);
    while (exp_q.size() != 0 || obs_q.size() != 0) begin
      compared++;
      if (exp_q.size() == 0) begin
        o = obs_q.pop_front(); mismatched++;
        $display("FAIL pause_seq: got %h fin=%b @%0d required no update", o.t, o.fin, o.at);
      end else if (obs_q.size() == 0) begin
        e = exp_q.pop_front(); mismatched++;
        $display("FAIL pause_seq: got no update required %h @%0d", e.t, e.at);
      end else begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        if (o.t !== e.t || o.at !== e.at || o.fin !== e.fin) begin
          mismatched++;
          $display("FAIL pause_seq: got %h fin=%b @%0d required %h fin=%b @%0d", o.t, o.fin, o.at, e.t, e.fin, e.at);
        end
      end
    end
  endtask

  task automatic test_clamp_and_zero_start();
    idle_load(24'h3A7F99);
    compared++; if (now_t() !== 24'h235959) begin mismatched++; $display("FAIL clamp_a: got %h required 235959", now_t()); end
    idle_load(24'h1C4EB2);
    compared++; if (now_t() !== 24'h194959) begin mismatched++; $display("FAIL clamp_b: got %h required 194959", now_t()); end
    idle_load(24'h000000);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    compared++; if (ifc.RUNNING !== 1'b0) begin mismatched++; $display("FAIL zero_start: got run=%b required 0", ifc.RUNNING); end
    observe(30);
    compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL zero_start_quiet: got %0d events required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_ack_and_priority();
    idle_load(24'h000001);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    observe(15);
    compared++;
    if (obs_q.size() != 1 || obs_q[0].t !== 24'h0 || obs_q[0].at != 10 || obs_q[0].fin !== 1'b1) begin
      mismatched++; $display("FAIL one_sec_expiry: got %0d events required one 000000 fin=1 @10", obs_q.size());
    end
    obs_q.delete();
    strobe(1'b0, 1'b1, 1'b1, 1'b0);
    compared++; if (ifc.DONE !== 1'b1) begin mismatched++; $display("FAIL done_ignores_start: got done=%b required 1", ifc.DONE); end
    strobe(1'b0, 1'b0, 1'b0, 1'b1);
    compared++; if (ifc.DONE !== 1'b0 || ifc.RUNNING !== 1'b0 || now_t() !== 24'h0) begin mismatched++; $display("FAIL ack_idle: got done=%b run=%b t=%h required 0 0 000000", ifc.DONE, ifc.RUNNING, now_t()); end
    idle_load(24'h000001);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    observe(10);
    obs_q.delete();
    set_inputs(24'h000007);
    strobe(1'b1, 1'b0, 1'b0, 1'b1);
    compared++; if (ifc.DONE !== 1'b0 || now_t() !== 24'h000007) begin mismatched++; $display("FAIL ack_load_together: got done=%b t=%h required 0 000007", ifc.DONE, now_t()); end
    set_inputs(24'h000004);
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    compared++; if (ifc.RUNNING !== 1'b0 || now_t() !== 24'h000004) begin mismatched++; $display("FAIL load_beats_start: got run=%b t=%h required 0 000004", ifc.RUNNING, now_t()); end
  endtask

  task automatic test_stop_start_same();
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, 1'b0);
    compared++; if (ifc.RUNNING !== 1'b0) begin mismatched++; $display("FAIL stop_beats_start: got run=%b required 0", ifc.RUNNING); end
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    compared++; if (ifc.RUNNING !== 1'b1) begin mismatched++; $display("FAIL resume: got run=%b required 1", ifc.RUNNING); end
  endtask

  task automatic test_stop_on_tick();
    idle_load(24'h000001);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    observe(9);
    compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL stop_tick_early: got %0d events required 0", obs_q.size()); end
    obs_q.delete();
    strobe(1'b0, 1'b0, 1'b1, 1'b0);
    compared++;
    if (now_t() !== 24'h0 || ifc.DONE !== 1'b1 || ifc.RUNNING !== 1'b0 || ifc.FIN_CRONOM !== 1'b1) begin
      mismatched++; $display("FAIL stop_on_tick: got t=%h done=%b run=%b fin=%b required 000000 1 0 1", now_t(), ifc.DONE, ifc.RUNNING, ifc.FIN_CRONOM);
    end
    observe(20);
    compared++; if (obs_q.size() != 0) begin mismatched++; $display("FAIL fin_once: got %0d later events required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_midrun();
    int fins;
    idle_load(24'h000009);
    strobe(1'b0, 1'b1, 1'b0, 1'b0);
    observe(7);
    obs_q.delete();
    RST = 1'b1;
    #2;
    compared++;
    if (now_t() !== 24'h0 || ifc.RUNNING !== 1'b0 || ifc.DONE !== 1'b0 || ifc.FIN_CRONOM !== 1'b0) begin
      mismatched++; $display("FAIL async_reset: got t=%h run=%b done=%b fin=%b required all 0", now_t(), ifc.RUNNING, ifc.DONE, ifc.FIN_CRONOM);
    end
    fins = 0;
    for (int i = 0; i < 3; i++) begin step(); if (ifc.FIN_CRONOM) fins++; end
    RST = 1'b0;
    for (int i = 0; i < 15; i++) begin step(); if (ifc.FIN_CRONOM) fins++; end
    compared++; if (fins != 0 || ifc.RUNNING !== 1'b0 || now_t() !== 24'h0) begin mismatched++; $display("FAIL reset_no_fin: got fins=%0d run=%b t=%h required 0 0 000000", fins, ifc.RUNNING, now_t()); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_clamp_and_zero_start();
    test_ack_and_priority();
    test_stop_start_same();
    test_stop_on_tick();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
